// File: rtl/gobou_bias_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gobou_bias_ctrl_pkg
//   Shared definitions for the gobou fully-connected bias stage:
//   default widths and the controller state encoding.
//   GOBOU_DWIDTH describes the bias datapath word; the controller itself never
//   touches data, so only the environment around it uses that width.
// -----------------------------------------------------------------------------
package gobou_bias_ctrl_pkg;

  localparam int GOBOU_DWIDTH = 16;  // datapath word width
  localparam int GOBOU_BADDR  = 12;  // bias RAM address width
  localparam int GOBOU_NWIDTH = 12;  // neuron count / index width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LD   = 3'd2,
    S_WAIT = 3'd3,
    S_ADD  = 3'd4,
    S_EMIT = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/gobou_bias_ctrl.sv
// -----------------------------------------------------------------------------
// gobou_bias_ctrl
//   Sequencer for the gobou fully-connected bias stage. Per output neuron it
//   reads one bias word (RD), loads the bias register (LD), accepts the
//   accumulator result via acc_valid/acc_ready (WAIT), enables the output
//   register (ADD) and flags the result with its neuron index (EMIT).
//   After the last neuron it pulses ack for one cycle (DONE).
//
// Ports
//   clk        clock
//   xrst       synchronous active-low reset
//   req        start pulse, honoured only in IDLE
//   out_size   number of output neurons, latched at req
//   bias_base  bias RAM base address, latched at req
//   acc_valid  accumulator result present on the datapath
//   acc_ready  result accepted this cycle (WAIT only)
//   bias_addr  bias RAM read address
//   bias_re    bias RAM read enable
//   breg_we    bias register load enable
//   out_en     datapath output-register update enable
//   out_valid  datapath pixel_out valid this cycle
//   out_idx    neuron index of pixel_out while out_valid
//   busy       high in every state except IDLE
//   ack        one-cycle layer-complete pulse
//   stall_cnt  cycles spent in WAIT without acc_valid
//              (present only with GOBOU_BIAS_STALL_CNT_EN defined)
//
// Build option: define GOBOU_BIAS_STALL_CNT_EN to add the stall counter.
// All outputs decode from registered state only; no input reaches an output.
// -----------------------------------------------------------------------------
module gobou_bias_ctrl
  import gobou_bias_ctrl_pkg::*;
#(
  parameter int BADDR  = GOBOU_BADDR,
  parameter int NWIDTH = GOBOU_NWIDTH
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [NWIDTH-1:0] out_size,
  input  logic [BADDR-1:0]  bias_base,
  input  logic              acc_valid,
  output logic              acc_ready,
  output logic [BADDR-1:0]  bias_addr,
  output logic              bias_re,
  output logic              breg_we,
  output logic              out_en,
  output logic              out_valid,
  output logic [NWIDTH-1:0] out_idx,
  output logic              busy,
`ifdef GOBOU_BIAS_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              ack
);

  state_t              state, state_nxt;
  logic [NWIDTH-1:0]   idx;
  logic [NWIDTH-1:0]   size;
  logic [BADDR-1:0]    base;
  logic                last;
  logic                start;

  assign start = (state == S_IDLE) && req;
  // size is non-zero whenever this is consulted (EMIT), so size-1 cannot
  // underflow; a full-range size therefore never wraps idx.
  assign last  = (idx == size - 1'b1);

  // State and layer registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state <= S_IDLE;
      idx   <= '0;
      size  <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        size <= out_size;
        base <= bias_base;
        idx  <= '0;
      end else if (state == S_EMIT && !last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (req) state_nxt = (out_size == '0) ? S_DONE : S_RD;
      S_RD:   state_nxt = S_LD;
      S_LD:   state_nxt = S_WAIT;
      S_WAIT: if (acc_valid) state_nxt = S_ADD;
      S_ADD:  state_nxt = S_EMIT;
      S_EMIT: state_nxt = last ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode. bias_addr wraps modulo 2^BADDR; idx is resized to the
  // address width before the add.
  always_comb begin
    acc_ready = 1'b0;
    bias_addr = '0;
    bias_re   = 1'b0;
    breg_we   = 1'b0;
    out_en    = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    busy      = (state != S_IDLE);
    ack       = 1'b0;
    unique case (state)
      S_RD: begin
        bias_re   = 1'b1;
        bias_addr = base + BADDR'(idx);
      end
      S_LD:   breg_we   = 1'b1;
      S_WAIT: acc_ready = 1'b1;
      S_ADD:  out_en    = 1'b1;
      S_EMIT: begin
        out_valid = 1'b1;
        out_idx   = idx;
      end
      S_DONE: ack = 1'b1;
      default: ;
    endcase
  end

`ifdef GOBOU_BIAS_STALL_CNT_EN
  // Counts WAIT cycles starved of acc_valid; cleared only by an accepted req,
  // so the final value stays readable after ack.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      stall_cnt <= '0;
    end else if (start) begin
      stall_cnt <= '0;
    end else if (state == S_WAIT && !acc_valid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gobou_bias_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gobou_bias_ctrl
//   Bench for gobou_bias_ctrl. A small datapath (bias RAM with 1-cycle read,
//   bias register, registered pixel_in, output register) surrounds the DUT.
//   Expected addresses, handshake cycles, results and ack timing come from
//   per-neuron arithmetic over the layer description.
//   Define GOBOU_BIAS_STALL_CNT_EN to also check stall_cnt.
// -----------------------------------------------------------------------------
module tb_gobou_bias_ctrl;
  import gobou_bias_ctrl_pkg::*;

  localparam int BW = GOBOU_BADDR;
  localparam int NW = GOBOU_NWIDTH;
  localparam int DW = GOBOU_DWIDTH;
  localparam int AMASK = (1 << BW) - 1;

  logic          clk;
  logic          xrst;
  logic          req;
  logic [NW-1:0] out_size;
  logic [BW-1:0] bias_base;
  logic          acc_valid;
  logic          acc_ready;
  logic [BW-1:0] bias_addr;
  logic          bias_re;
  logic          breg_we;
  logic          out_en;
  logic          out_valid;
  logic [NW-1:0] out_idx;
  logic          busy;
  logic          ack;
`ifdef GOBOU_BIAS_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  gobou_bias_ctrl dut (
    .clk       (clk),
    .xrst      (xrst),
    .req       (req),
    .out_size  (out_size),
    .bias_base (bias_base),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .bias_addr (bias_addr),
    .bias_re   (bias_re),
    .breg_we   (breg_we),
    .out_en    (out_en),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .busy      (busy),
`ifdef GOBOU_BIAS_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Surrounding datapath.
  logic signed [DW-1:0] bias_mem [0:(1<<BW)-1];
  logic signed [DW-1:0] acc_data;
  logic signed [DW-1:0] read_bias;
  logic signed [DW-1:0] breg;
  logic signed [DW-1:0] pixel_in_r;
  logic signed [DW-1:0] pixel_out;

  always @(posedge clk) begin
    if (bias_re) read_bias <= bias_mem[bias_addr];
    if (breg_we) breg <= read_bias;
    pixel_in_r <= acc_data;
    if (out_en) pixel_out <= pixel_in_r + breg;
  end

  // mode 0: acc_valid raised early (already high in RD/LD), no stall
  // mode 1: random stall 0..4 cycles per neuron
  // mode 2: stall of exactly 6 cycles per neuron
  task automatic run_layer(input string name, input int n, input int base, input int mode,
                           input bit poke_req, input bit force_acc0);
    int delays[$];
    logic signed [DW-1:0] accs[$];
    int addr_q[$], re_cyc[$], we_cyc[$], hs_cyc[$], en_cyc[$], ov_cyc[$], ov_idx[$], ack_cyc[$];
    logic signed [DW-1:0] ov_pix[$];
    logic signed [DW-1:0] exp_pix;
    int exp_total, exp_hs, start, stall_sum, nh, wcount, cyc, budget, busy_bad, a;
    bit hs_prev;

    stall_sum = 0;
    start = 1;
    for (int i = 0; i < n; i++) begin
      delays.push_back(mode == 0 ? 0 : (mode == 1 ? int'($urandom_range(0, 4)) : 6));
      accs.push_back(DW'($urandom));
      stall_sum += delays[i];
      start += 5 + delays[i];
    end
    if (force_acc0 && n > 0) accs[0] = 16'sd100;
    exp_total = start;  // cycle index of DONE, counting the req cycle as 0

    @(negedge clk);
    req = 1'b1;
    out_size = NW'(n);
    bias_base = BW'(base);
    acc_valid = (mode == 0 && n > 0);
    if (n > 0) acc_data = accs[0];
    cyc = 0; nh = 0; wcount = 0; busy_bad = 0; hs_prev = 1'b0;
    budget = exp_total + 20;

    while (cyc < budget && !(ack_cyc.size() > 0 && cyc >= ack_cyc[0] + 2)) begin
      @(negedge clk);
      cyc++;
      req = poke_req && (cyc == 3);
      if (req) begin
        out_size = NW'($urandom);
        bias_base = BW'($urandom);
      end
      if (bias_re)   begin addr_q.push_back(int'(bias_addr)); re_cyc.push_back(cyc); end
      if (breg_we)   we_cyc.push_back(cyc);
      if (out_en)    en_cyc.push_back(cyc);
      if (out_valid) begin ov_cyc.push_back(cyc); ov_idx.push_back(int'(out_idx)); ov_pix.push_back(pixel_out); end
      if (ack)       ack_cyc.push_back(cyc);
      if (busy !== (cyc <= exp_total)) busy_bad++;
      if (hs_prev) begin
        hs_prev = 1'b0;
        acc_valid = (mode == 0 && nh < n);
        if (nh < n) acc_data = accs[nh];
      end
      if (nh < n && acc_ready) begin
        if (!acc_valid) begin
          if (wcount == delays[nh]) begin
            acc_valid = 1'b1;
            acc_data = accs[nh];
          end else begin
            wcount++;
          end
        end
        if (acc_valid) begin
          hs_cyc.push_back(cyc);
          nh++;
          wcount = 0;
          hs_prev = 1'b1;
        end
      end
    end
    req = 1'b0;
    acc_valid = 1'b0;

    checks++;
    if (ack_cyc.size() != 1) begin
      errors++;
      $display("FAIL %s ack_count: got %0d expected 1", name, ack_cyc.size());
    end
    checks++;
    if (ack_cyc.size() == 0 || ack_cyc[0] != exp_total) begin
      errors++;
      $display("FAIL %s ack_cycle: got %0d expected %0d", name,
               ack_cyc.size() == 0 ? -1 : ack_cyc[0], exp_total);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy: %0d wrong cycles, expected 0", name, busy_bad);
    end
    checks++;
    if (addr_q.size() != n || we_cyc.size() != n || hs_cyc.size() != n ||
        en_cyc.size() != n || ov_cyc.size() != n) begin
      errors++;
      $display("FAIL %s event_counts: re %0d we %0d hs %0d en %0d ov %0d expected %0d each",
               name, addr_q.size(), we_cyc.size(), hs_cyc.size(), en_cyc.size(), ov_cyc.size(), n);
    end else begin
      start = 1;
      for (int i = 0; i < n; i++) begin
        a = (base + i) & AMASK;
        exp_hs = start + 2 + delays[i];
        start += 5 + delays[i];
        exp_pix = accs[i] + bias_mem[a];
        checks++;
        if (addr_q[i] != a) begin
          errors++;
          $display("FAIL %s bias_addr[%0d]: got %h expected %h", name, i, addr_q[i], a);
        end
        checks++;
        if (we_cyc[i] != re_cyc[i] + 1) begin
          errors++;
          $display("FAIL %s breg_we[%0d]: got cycle %0d expected %0d", name, i, we_cyc[i], re_cyc[i] + 1);
        end
        checks++;
        if (hs_cyc[i] != exp_hs) begin
          errors++;
          $display("FAIL %s handshake[%0d]: got cycle %0d expected %0d", name, i, hs_cyc[i], exp_hs);
        end
        checks++;
        if (en_cyc[i] != hs_cyc[i] + 1) begin
          errors++;
          $display("FAIL %s out_en[%0d]: got cycle %0d expected %0d", name, i, en_cyc[i], hs_cyc[i] + 1);
        end
        checks++;
        if (ov_cyc[i] != hs_cyc[i] + 2 || ov_idx[i] != i) begin
          errors++;
          $display("FAIL %s out_valid[%0d]: got cycle %0d idx %0d expected cycle %0d idx %0d",
                   name, i, ov_cyc[i], ov_idx[i], hs_cyc[i] + 2, i);
        end
        checks++;
        if (ov_pix[i] !== exp_pix) begin
          errors++;
          $display("FAIL %s pixel_out[%0d]: got %0d expected %0d", name, i, ov_pix[i], exp_pix);
        end
      end
    end
`ifdef GOBOU_BIAS_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'(stall_sum)) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, stall_sum);
    end
`endif
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bias_re, breg_we, acc_ready, out_en, out_valid, busy, ack, bias_addr, out_idx} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got re%b we%b rdy%b en%b ov%b busy%b ack%b addr%h idx%h expected all 0",
               bias_re, breg_we, acc_ready, out_en, out_valid, busy, ack, bias_addr, out_idx);
    end
`ifdef GOBOU_BIAS_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    xrst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle_after_release: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int nv, cyc, ack_seen, busy_seen;
    bit hit;
    @(negedge clk);
    req = 1'b1; out_size = NW'(4); bias_base = BW'('h100); acc_valid = 1'b0;
    nv = 0; cyc = 0; hit = 1'b0;
    while (cyc < 60 && !hit) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      if (out_valid) nv++;
      if (acc_ready && nv >= 2) begin
        hit = 1'b1;
        acc_valid = 1'b0;
      end else begin
        acc_valid = acc_ready;
        acc_data = DW'($urandom);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid reach_wait2: got no WAIT of neuron 2 expected within 60 cycles");
    end
    xrst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bias_re, breg_we, acc_ready, out_en, out_valid, busy, ack, bias_addr, out_idx} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got re%b we%b rdy%b en%b ov%b busy%b ack%b expected all 0",
               bias_re, breg_we, acc_ready, out_en, out_valid, busy, ack);
    end
    xrst = 1'b1;
    ack_seen = 0; busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) ack_seen++;
      if (busy) busy_seen++;
    end
    checks++;
    if (ack_seen != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL reset_mid no_ack: got ack %0d busy %0d cycles expected 0 0", ack_seen, busy_seen);
    end
    run_layer("reset_mid_restart", 3, int'($urandom_range(0, AMASK)), 1, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    bias_mem['h010] = -16'sd7;
    run_layer("basic", 3, 'h010, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    run_layer("stall", 3, 'h200, 2, 1'b0, 1'b0);
  endtask

  task automatic test_zero_size();
    run_layer("zero_size", 0, 'h123, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    run_layer("ignored_inputs", 4, 'h040, 0, 1'b1, 1'b0);
  endtask

  task automatic test_addr_wrap();
    run_layer("addr_wrap", 2, 'hFFF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_layer("random", int'($urandom_range(1, 8)), int'($urandom_range(0, AMASK)), 1, k[0], 1'b0);
  endtask

  task automatic test_max_size();
    run_layer("max_size", (1 << NW) - 1, int'($urandom_range(0, AMASK)), 0, 1'b0, 1'b0);
  endtask

  initial begin
    xrst = 1'b0; req = 1'b0; out_size = '0; bias_base = '0;
    acc_valid = 1'b0; acc_data = '0;
    for (int i = 0; i < (1 << BW); i++) bias_mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_ignored_inputs();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    test_max_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
